// File: rtl/fault_free.sv
// fault_free
//   Reference netlist for the DFT fault-simulation flow. It has two parts:
//   - a combinational copy of the netlist whose output K honours the
//     externally driven stuck-at fault controls G0/E0/J1
//   - a clocked 4-lane parallel evaluator that runs the fault-free circuit
//     and three single-fault circuits on a captured test vector in one pass,
//     and reports which of those faults the vector detects.
//
// Ports
//   clk    : rising-edge clock for the evaluator
//   rst_n  : asynchronous active-low reset (evaluator only)
//   A..D   : primary inputs, A is the MSB of the test vector
//   G0     : 1 = G fault-free, 0 = G stuck-at-0 (K path only)
//   E0     : 1 = E fault-free, 0 = E stuck-at-0 (K path only)
//   J1     : 0 = J fault-free, 1 = J stuck-at-1 (K path only)
//   K      : combinational circuit output with fault controls applied
//   start  : request an evaluation of the current A..D
//   word   : lane responses [3] fault-free, [2] E/0, [1] G/0, [0] J/1
//   det    : detection flags [2] E/0, [1] G/0, [0] J/1
//   done   : one-cycle pulse, word/det freshly updated
module fault_free (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       G0,
  input  logic       E0,
  input  logic       J1,
  output logic       K,
  input  logic       start,
  output logic [3:0] word,
  output logic [2:0] det,
  output logic       done
);

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  // Lane masks: a 0 in an AND mask forces that lane's net to 0, a 1 in an
  // OR mask forces it to 1. Lane order is {fault-free, E/0, G/0, J/1}.
  localparam logic [3:0] LaneMaskE = 4'b1011;
  localparam logic [3:0] LaneMaskG = 4'b1101;
  localparam logic [3:0] LaneMaskJ = 4'b0001;

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_vec;
  logic [3:0] r_word;
  logic [2:0] r_det;
  logic       r_done;
  logic       w_capture;
  logic       w_finish;

  // Combinational netlist with injected faults.
  logic w_e;
  logic w_f;
  logic w_g;
  logic w_h;
  logic w_j;

  assign w_e = A & B & E0;
  assign w_f = ~(C & D);
  assign w_g = w_e & w_f & G0;
  assign w_h = C ^ D;
  assign w_j = ~(w_g & w_h) | J1;
  assign K   = ~w_j;

  // Bit-parallel evaluation of the captured vector. Every net is a 4-lane
  // vector; fault-free nets are simply replicated across all lanes.
  logic [3:0] w_laneE;
  logic [3:0] w_laneF;
  logic [3:0] w_laneG;
  logic [3:0] w_laneH;
  logic [3:0] w_laneJ;
  logic [3:0] w_laneK;
  logic [2:0] w_laneDet;

  assign w_laneE   = {4{r_vec[3] & r_vec[2]}} & LaneMaskE;
  assign w_laneF   = {4{~(r_vec[1] & r_vec[0])}};
  assign w_laneG   = w_laneE & w_laneF & LaneMaskG;
  assign w_laneH   = {4{r_vec[1] ^ r_vec[0]}};
  assign w_laneJ   = ~(w_laneG & w_laneH) | LaneMaskJ;
  assign w_laneK   = ~w_laneJ;
  // A fault is detected when its lane differs from the fault-free lane.
  assign w_laneDet = {3{w_laneK[3]}} ^ w_laneK[2:0];

  // Evaluator state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a start in IDLE captures the vector, EVAL always lasts
  // exactly one cycle and ignores start.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_nextState = EVAL;
        end
      end
      EVAL: begin
        w_finish    = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Capture register and result registers. Results hold until the next
  // evaluation completes; done is a single-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec  <= 4'b0000;
      r_word <= 4'b0000;
      r_det  <= 3'b000;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_capture) begin
        r_vec <= {A, B, C, D};
      end
      if (w_finish) begin
        r_word <= w_laneK;
        r_det  <= w_laneDet;
      end
    end
  end

  assign word = r_word;
  assign det  = r_det;
  assign done = r_done;

endmodule

// File: tb/tb_fault_free.sv
// tb_fault_free
//   Randomised scoreboard bench for fault_free. The stimulus side models the
//   evaluator as "one accepted request per two cycles" and pushes the
//   expected {word, det} when an accepted request completes; a monitor pops
//   and compares whenever done is seen. Expected responses come from a
//   scalar boolean evaluation of the netlist, once per fault scenario.
module tb_fault_free;

  logic       clk;
  logic       rst_n;
  logic       A, B, C, D;
  logic       G0, E0, J1;
  logic       K;
  logic       start;
  logic [3:0] word;
  logic [2:0] det;
  logic       done;

  int         totalChecks = 0;
  int         badChecks   = 0;

  logic [6:0] expQ[$];
  logic       modelBusy   = 1'b0;
  logic [3:0] pendingVec  = 4'b0000;
  logic [3:0] lastWord    = 4'b0000;
  logic [2:0] lastDet     = 3'b000;

  fault_free dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .G0    (G0),
    .E0    (E0),
    .J1    (J1),
    .K     (K),
    .start (start),
    .word  (word),
    .det   (det),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scalar netlist evaluation for one fault scenario.
  function automatic logic netK(input logic a, input logic b, input logic c,
                                input logic d, input bit eSa0, input bit gSa0,
                                input bit jSa1);
    logic e, f, g, h, j;
    e = (a && b) && !eSa0;
    f = !(c && d);
    g = e && f && !gSa0;
    h = (c != d);
    j = !(g && h) || jSa1;
    return !j;
  endfunction

  // Expected {word, det} for a test vector {A,B,C,D}.
  function automatic logic [6:0] expected(input logic [3:0] v);
    logic ff, fe, fg, fj;
    ff = netK(v[3], v[2], v[1], v[0], 0, 0, 0);
    fe = netK(v[3], v[2], v[1], v[0], 1, 0, 0);
    fg = netK(v[3], v[2], v[1], v[0], 0, 1, 0);
    fj = netK(v[3], v[2], v[1], v[0], 0, 0, 1);
    return {ff, fe, fg, fj, ff ^ fe, ff ^ fg, ff ^ fj};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] required);
    totalChecks++;
    if (actual !== required) begin
      badChecks++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Advance one clock and update the request model: a request is accepted
  // when the model is idle, and completes on the following edge unless
  // reset intervenes.
  task automatic tick();
    logic       complete, accept;
    logic [3:0] v;
    complete = modelBusy && rst_n;
    accept   = !modelBusy && start && rst_n;
    v        = {A, B, C, D};
    @(posedge clk);
    if (complete) expQ.push_back(expected(pendingVec));
    if (accept) pendingVec = v;
    modelBusy = accept;
    #1;
  endtask

  // Issue one start pulse with vector v; optionally scramble A..D right
  // after capture, then leave `gap` idle cycles.
  task automatic applyStimulus(input logic [3:0] v, input bit scramble, input int gap);
    {A, B, C, D} = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) {A, B, C, D} = 4'($urandom_range(0, 15));
    tick();
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic checkK(input logic [3:0] v, input logic g0, input logic e0,
                        input logic j1);
    {A, B, C, D} = v;
    G0 = g0;
    E0 = e0;
    J1 = j1;
    #1;
    checkOutput("K", {7'b0, K}, {7'b0, netK(v[3], v[2], v[1], v[0], !e0, !g0, j1)});
  endtask

  // Monitor: checks reset values, scoreboard results on done, and that
  // results hold between evaluations.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("resetState", {1'b0, word, det}, 8'h00);
      checkOutput("resetDone", {7'b0, done}, 8'h00);
      lastWord = 4'b0000;
      lastDet  = 3'b000;
    end else if (done) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousDone", {7'b0, done}, 8'h00);
      end else begin
        logic [6:0] e;
        e = expQ.pop_front();
        checkOutput("word", {4'b0, word}, {4'b0, e[6:3]});
        checkOutput("det", {5'b0, det}, {5'b0, e[2:0]});
        lastWord = e[6:3];
        lastDet  = e[2:0];
      end
    end else begin
      checkOutput("hold", {1'b0, word, det}, {1'b0, lastWord, lastDet});
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    {A, B, C, D} = 4'b0000;
    G0 = 1'b1;
    E0 = 1'b1;
    J1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] combinational K checks");
    checkK(4'b1110, 1, 1, 0);
    checkK(4'b1110, 1, 0, 0);
    checkK(4'b1110, 0, 1, 0);
    checkK(4'b1110, 1, 1, 1);
    checkK(4'b0000, 1, 1, 0);
    checkK(4'b0000, 1, 0, 0);
    checkK(4'b0000, 0, 1, 0);
    checkK(4'b0000, 1, 1, 1);
    for (int i = 0; i < 40; i++) begin
      checkK(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    G0 = 1'b1;
    E0 = 1'b1;
    J1 = 1'b0;
    tick();

    $display("[TB] directed evaluations");
    applyStimulus(4'b1110, 0, 2);
    applyStimulus(4'b1111, 0, 1);
    applyStimulus(4'b0010, 0, 1);
    applyStimulus(4'b1101, 0, 1);
    // Inputs change during EVAL; result must reflect the captured 1110.
    {A, B, C, D} = 4'b1110;
    start = 1'b1;
    tick();
    start = 1'b0;
    {A, B, C, D} = 4'b0000;
    tick();
    tick();

    $display("[TB] reset during evaluation");
    {A, B, C, D} = 4'b1110;
    start = 1'b1;
    tick();
    start = 1'b0;
    rst_n = 1'b0;
    modelBusy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(4'b1101, 0, 1);

    $display("[TB] start held high");
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      {A, B, C, D} = 4'($urandom_range(0, 15));
      tick();
    end
    start = 1'b0;
    tick();
    tick();

    $display("[TB] random evaluations");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 2));
    end

    for (int i = 0; i < 4; i++) tick();
    checkOutput("pendingResults", 8'(expQ.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
